// File: rtl/lbm_pkg.sv
// Shared LBM lattice constants, population/cell record types and small arithmetic helpers
// used by the lattice writer/reader and the streaming stage.
package lbm_pkg;

  localparam int BRAM_DEPTH = 31570;
  localparam int LATTICE_W  = 205;
  localparam int LATTICE_H  = BRAM_DEPTH / LATTICE_W;
  localparam int BRAM_SIZE  = $clog2(BRAM_DEPTH);
  localparam int RD_LATENCY = 2;
  localparam int FIFO_DEPTH = 4;

  localparam int NUM_DIRS = 9;
  localparam int DIR_C  = 0;
  localparam int DIR_N  = 1;
  localparam int DIR_NE = 2;
  localparam int DIR_E  = 3;
  localparam int DIR_SE = 4;
  localparam int DIR_S  = 5;
  localparam int DIR_SW = 6;
  localparam int DIR_W  = 7;
  localparam int DIR_NW = 8;

  typedef logic [7:0] population_t;
  typedef population_t [NUM_DIRS-1:0] cell_pops_t;

  typedef struct packed {
    logic [7:0]         x;
    logic [7:0]         y;
    logic [11:0]        rho;
    logic signed [10:0] ux;
    logic signed [10:0] uy;
  } cell_stats_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_DRAIN
  } reader_state_t;

  // Zero-extended partial sum of three populations; 10 bits holds 3 * 255.
  function automatic logic [9:0] sum3(input population_t a, input population_t b,
                                      input population_t c);
    return 10'(a) + 10'(b) + 10'(c);
  endfunction

endpackage

// File: rtl/lattice_reader_if.sv
// BRAM read port plus the per-cell valid/ready output stream of the lattice reader.
interface lattice_reader_if;
  import lbm_pkg::*;

  logic [BRAM_SIZE-1:0] addr_out;
  cell_pops_t           bram_data_in;
  logic                 cell_valid_out;
  logic                 cell_ready_in;
  logic [7:0]           cell_x_out;
  logic [7:0]           cell_y_out;
  logic [11:0]          cell_rho_out;
  logic signed [10:0]   cell_ux_out;
  logic signed [10:0]   cell_uy_out;

  modport master (
    output addr_out,
    input  bram_data_in,
    output cell_valid_out,
    input  cell_ready_in,
    output cell_x_out,
    output cell_y_out,
    output cell_rho_out,
    output cell_ux_out,
    output cell_uy_out
  );

  modport slave (
    input  addr_out,
    output bram_data_in,
    input  cell_valid_out,
    output cell_ready_in,
    input  cell_x_out,
    input  cell_y_out,
    input  cell_rho_out,
    input  cell_ux_out,
    input  cell_uy_out
  );

endinterface

// File: rtl/lbm_fifo.sv
// Small first-word-fall-through FIFO of cell records; simultaneous write and read are both honoured,
// including a write while full when the head is popped in the same cycle.
module lbm_fifo
  import lbm_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic                       wr_en,
  input  cell_stats_t                wr_data,
  input  logic                       rd_en,
  output cell_stats_t                rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  cell_stats_t      mem_reg [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             do_wr;
  logic             do_rd;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign do_rd = rd_en && !empty;
  assign do_wr = wr_en && (!full || do_rd);

  // Storage is cleared on reset so the exposed head reads as zero while idle.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < DEPTH; i++) mem_reg[i] <= '0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_wr) begin
        mem_reg[wr_ptr_reg] <= wr_data;
        wr_ptr_reg          <= ptr_inc(wr_ptr_reg);
      end
      if (do_rd) rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      if (do_wr && !do_rd) count_reg <= count_reg + CNT_W'(1);
      else if (!do_wr && do_rd) count_reg <= count_reg - CNT_W'(1);
    end
  end

  assign rd_data = mem_reg[rd_ptr_reg];
  assign count   = count_reg;
  assign empty   = (count_reg == '0);
  assign full    = (count_reg == CNT_W'(DEPTH));

endmodule

// File: rtl/lattice_reader.sv
// Sweeps the lattice BRAM in address order and streams per-cell density, momentum and coordinates
// through a credit-limited FIFO so the consumer may stall without losing cells.
module lattice_reader
  import lbm_pkg::*;
(
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             start_in,
  output logic             busy_out,
  output logic             done_out,
  lattice_reader_if.master bus
);

  localparam logic [BRAM_SIZE-1:0] LAST_ADDR = BRAM_SIZE'(BRAM_DEPTH - 1);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int INF_W = $clog2(RD_LATENCY + 1);
  localparam int OCC_W = $clog2(FIFO_DEPTH + RD_LATENCY + 1);

  reader_state_t         state_reg;
  reader_state_t         state_next;
  logic [BRAM_SIZE-1:0]  addr_reg;
  logic [BRAM_SIZE-1:0]  addr_next;
  logic [RD_LATENCY-1:0] ret_pipe_reg;
  logic [7:0]            x_reg;
  logic [7:0]            y_reg;
  logic                  done_reg;

  logic [INF_W-1:0]      inflight;
  logic [OCC_W-1:0]      occupancy;
  logic [CNT_W-1:0]      fifo_count;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  issue;
  logic                  data_ret;
  logic                  pop;
  logic                  last_pop;
  logic                  scan_start;
  logic [9:0]            east_sum;
  logic [9:0]            west_sum;
  logic [9:0]            north_sum;
  logic [9:0]            south_sum;
  cell_stats_t           wr_cell;
  cell_stats_t           rd_cell;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LATENCY; i++) inflight = inflight + INF_W'(ret_pipe_reg[i]);
  end

  // Reads in flight already own a FIFO slot, so the FIFO can never overflow.
  assign occupancy  = OCC_W'(inflight) + OCC_W'(fifo_count);
  assign issue      = (state_reg == ST_SCAN) && (occupancy < OCC_W'(FIFO_DEPTH)) && !fifo_full;
  assign data_ret   = ret_pipe_reg[RD_LATENCY-1];
  assign pop        = bus.cell_valid_out && bus.cell_ready_in;
  assign last_pop   = (state_reg == ST_DRAIN) && pop && (inflight == '0) &&
                      (fifo_count == CNT_W'(1));
  assign scan_start = (state_reg == ST_IDLE) && start_in;

  always_comb begin
    state_next = state_reg;
    addr_next  = addr_reg;
    unique case (state_reg)
      ST_IDLE: begin
        if (start_in) state_next = ST_SCAN;
      end
      ST_SCAN: begin
        if (issue) begin
          if (addr_reg == LAST_ADDR) state_next = ST_DRAIN;
          else addr_next = addr_reg + BRAM_SIZE'(1);
        end
      end
      ST_DRAIN: begin
        if (last_pop) begin
          state_next = ST_IDLE;
          addr_next  = '0;
        end
      end
      default: begin
        state_next = ST_IDLE;
        addr_next  = '0;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_reg    <= ST_IDLE;
      addr_reg     <= '0;
      ret_pipe_reg <= '0;
      x_reg        <= '0;
      y_reg        <= '0;
      done_reg     <= 1'b0;
    end else begin
      state_reg       <= state_next;
      addr_reg        <= addr_next;
      done_reg        <= last_pop;
      ret_pipe_reg[0] <= issue;
      for (int i = 1; i < RD_LATENCY; i++) ret_pipe_reg[i] <= ret_pipe_reg[i-1];
      if (scan_start) begin
        x_reg <= '0;
        y_reg <= '0;
      end else if (data_ret) begin
        if (x_reg == 8'(LATTICE_W - 1)) begin
          x_reg <= '0;
          y_reg <= y_reg + 8'd1;
        end else begin
          x_reg <= x_reg + 8'd1;
        end
      end
    end
  end

  assign east_sum  = sum3(bus.bram_data_in[DIR_NE], bus.bram_data_in[DIR_E], bus.bram_data_in[DIR_SE]);
  assign west_sum  = sum3(bus.bram_data_in[DIR_SW], bus.bram_data_in[DIR_W], bus.bram_data_in[DIR_NW]);
  assign north_sum = sum3(bus.bram_data_in[DIR_NW], bus.bram_data_in[DIR_N], bus.bram_data_in[DIR_NE]);
  assign south_sum = sum3(bus.bram_data_in[DIR_SE], bus.bram_data_in[DIR_S], bus.bram_data_in[DIR_SW]);

  always_comb begin
    wr_cell     = '0;
    wr_cell.x   = x_reg;
    wr_cell.y   = y_reg;
    for (int d = 0; d < NUM_DIRS; d++) wr_cell.rho = wr_cell.rho + 12'(bus.bram_data_in[d]);
    wr_cell.ux  = 11'(east_sum) - 11'(west_sum);
    wr_cell.uy  = 11'(north_sum) - 11'(south_sum);
  end

  lbm_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .wr_en  (data_ret),
    .wr_data(wr_cell),
    .rd_en  (pop),
    .rd_data(rd_cell),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

  assign bus.addr_out       = addr_reg;
  assign bus.cell_valid_out = !fifo_empty;
  assign bus.cell_x_out     = rd_cell.x;
  assign bus.cell_y_out     = rd_cell.y;
  assign bus.cell_rho_out   = rd_cell.rho;
  assign bus.cell_ux_out    = rd_cell.ux;
  assign bus.cell_uy_out    = rd_cell.uy;
  assign busy_out           = (state_reg != ST_IDLE);
  assign done_out           = done_reg;

endmodule

// File: tb/tb_lattice_reader.sv
// Directed bench for lattice_reader: reset behaviour, full uniform scan with timing, and a
// backpressured scan over a patterned lattice with start pulses that must be ignored.
module tb_lattice_reader;
  import lbm_pkg::*;

  localparam int N = BRAM_DEPTH;

  logic clk_in = 1'b0;
  logic rst_in;
  logic start_in;
  logic busy_out;
  logic done_out;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   pattern = 0;
  cell_pops_t pipe1_reg;

  lattice_reader_if bus();

  lattice_reader dut (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .start_in(start_in),
    .busy_out(busy_out),
    .done_out(done_out),
    .bus     (bus)
  );

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  function automatic cell_pops_t gen_cell(input int idx);
    cell_pops_t p;
    p = '0;
    if (pattern == 0) begin
      for (int d = 0; d < NUM_DIRS; d++) p[d] = 8'd1;
      p[DIR_E] = 8'd15;
    end else if (idx == 0) begin
      p[DIR_NW] = 8'd255; p[DIR_N] = 8'd255; p[DIR_NE] = 8'd255;
    end else if (idx == 1) begin
      p[DIR_SW] = 8'd255; p[DIR_W] = 8'd255; p[DIR_NW] = 8'd255;
    end else begin
      for (int d = 0; d < NUM_DIRS; d++) p[d] = 8'((idx * 37 + d * 91 + (idx >> 3) * 13) % 256);
    end
    return p;
  endfunction

  // BRAM with two cycles of read latency.
  always @(posedge clk_in) begin
    pipe1_reg        <= gen_cell(int'(bus.addr_out));
    bus.bram_data_in <= pipe1_reg;
  end

  task automatic exp_cell(input int idx, output int ex, output int ey, output int erho,
                          output int eux, output int euy);
    cell_pops_t p;
    p = gen_cell(idx);
    erho = 0;
    for (int d = 0; d < NUM_DIRS; d++) erho += int'(p[d]);
    eux = int'(p[DIR_NE]) + int'(p[DIR_E]) + int'(p[DIR_SE])
        - int'(p[DIR_SW]) - int'(p[DIR_W]) - int'(p[DIR_NW]);
    euy = int'(p[DIR_NW]) + int'(p[DIR_N]) + int'(p[DIR_NE])
        - int'(p[DIR_SE]) - int'(p[DIR_S]) - int'(p[DIR_SW]);
    ex = idx % LATTICE_W;
    ey = idx / LATTICE_W;
  endtask

  task automatic test_reset();
    logic seen;
    rst_in = 1'b0;
    start_in = 1'b0;
    bus.cell_ready_in = 1'b1;
    pattern = 0;
    repeat (3) @(posedge clk_in);
    @(negedge clk_in) rst_in = 1'b1;
    @(posedge clk_in); #1;
    checks++;
    if (busy_out !== 1'b0 || done_out !== 1'b0 || bus.addr_out !== '0 || bus.cell_valid_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl got busy=%b done=%b addr=%0d valid=%b want 0 0 0 0",
               busy_out, done_out, bus.addr_out, bus.cell_valid_out);
    end
    checks++;
    if ({bus.cell_x_out, bus.cell_y_out, bus.cell_rho_out, bus.cell_ux_out, bus.cell_uy_out} !== 50'd0) begin
      errors++;
      $display("FAIL reset_data got x=%0d y=%0d rho=%0d want all 0", bus.cell_x_out, bus.cell_y_out,
               bus.cell_rho_out);
    end
    start_in = 1'b1;
    @(posedge clk_in); #1;
    start_in = 1'b0;
    repeat (10) @(posedge clk_in);
    #1;
    checks++;
    if (busy_out !== 1'b1 || bus.cell_valid_out !== 1'b1) begin
      errors++;
      $display("FAIL scan_running got busy=%b valid=%b want 1 1", busy_out, bus.cell_valid_out);
    end
    #3 rst_in = 1'b0;
    #1;
    checks++;
    if (busy_out !== 1'b0 || done_out !== 1'b0 || bus.addr_out !== '0 || bus.cell_valid_out !== 1'b0 ||
        {bus.cell_x_out, bus.cell_y_out, bus.cell_rho_out, bus.cell_ux_out, bus.cell_uy_out} !== 50'd0) begin
      errors++;
      $display("FAIL async_reset got busy=%b done=%b addr=%0d valid=%b x=%0d rho=%0d want all 0",
               busy_out, done_out, bus.addr_out, bus.cell_valid_out, bus.cell_x_out, bus.cell_rho_out);
    end
    @(posedge clk_in);
    @(negedge clk_in) rst_in = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk_in); #1;
      if (done_out !== 1'b0 || busy_out !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL reset_abort got done/busy activity=1 want 0 after reset mid-scan");
    end
  endtask

  task automatic test_uniform();
    int s, idx, done_cnt, done_cyc, post;
    int ex, ey, erho, eux, euy, ax, ay, arho, aux, auy;
    bit stop;
    pattern = 0;
    bus.cell_ready_in = 1'b1;
    @(posedge clk_in); #1;
    start_in = 1'b1;
    s = cyc;
    @(posedge clk_in); #1;
    start_in = 1'b0;
    checks++;
    if (busy_out !== 1'b1 || bus.addr_out !== '0) begin
      errors++;
      $display("FAIL start_accept got busy=%b addr=%0d want 1 0", busy_out, bus.addr_out);
    end
    idx = 0; done_cnt = 0; done_cyc = -1; post = 0; stop = 1'b0;
    for (int k = 0; k < N + 50 && !stop; k++) begin
      checks++;
      if (int'(bus.addr_out) > N - 1) begin
        errors++;
        $display("FAIL addr_range got %0d want <= %0d", bus.addr_out, N - 1);
      end
      if (done_out === 1'b1) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (bus.cell_valid_out === 1'b1) begin
        ax = int'(bus.cell_x_out); ay = int'(bus.cell_y_out); arho = int'(bus.cell_rho_out);
        aux = int'($signed(bus.cell_ux_out)); auy = int'($signed(bus.cell_uy_out));
        if (idx == 0) begin
          checks++;
          if (cyc != s + RD_LATENCY + 2) begin
            errors++;
            $display("FAIL first_valid_latency got cycle %0d want %0d", cyc - s, RD_LATENCY + 2);
          end
          checks++;
          if (arho != 23 || aux != 14 || auy != 0) begin
            errors++;
            $display("FAIL uniform_stats got rho=%0d ux=%0d uy=%0d want 23 14 0", arho, aux, auy);
          end
        end
        exp_cell(idx, ex, ey, erho, eux, euy);
        checks++;
        if (ax != ex || ay != ey || arho != erho || aux != eux || auy != euy) begin
          errors++;
          $display("FAIL uniform_cell idx=%0d got x=%0d y=%0d rho=%0d ux=%0d uy=%0d want %0d %0d %0d %0d %0d",
                   idx, ax, ay, arho, aux, auy, ex, ey, erho, eux, euy);
        end
        if (idx == 204 || idx == 205 || idx == N - 1) begin
          checks++;
          if ((idx == 204 && (ax != 204 || ay != 0)) || (idx == 205 && (ax != 0 || ay != 1)) ||
              (idx == N - 1 && (ax != 204 || ay != 153))) begin
            errors++;
            $display("FAIL coord_boundary idx=%0d got x=%0d y=%0d", idx, ax, ay);
          end
        end
        idx++;
      end
      if (done_cnt > 0) begin
        post++;
        if (post > 5) stop = 1'b1;
      end
      @(posedge clk_in); #1;
    end
    checks++;
    if (idx != N) begin
      errors++;
      $display("FAIL uniform_count got %0d cells want %0d", idx, N);
    end
    checks++;
    if (done_cnt != 1) begin
      errors++;
      $display("FAIL uniform_done_count got %0d want 1", done_cnt);
    end
    checks++;
    if (done_cyc != s + N + RD_LATENCY + 2) begin
      errors++;
      $display("FAIL done_timing got cycle %0d want %0d", done_cyc - s, N + RD_LATENCY + 2);
    end
    checks++;
    if (busy_out !== 1'b0 || bus.addr_out !== '0 || bus.cell_valid_out !== 1'b0) begin
      errors++;
      $display("FAIL uniform_idle got busy=%b addr=%0d valid=%b want 0 0 0", busy_out, bus.addr_out,
               bus.cell_valid_out);
    end
  endtask

  task automatic test_backpressure();
    int idx, done_cnt, post;
    int ex, ey, erho, eux, euy, ax, ay, arho, aux, auy;
    bit stop, stalled;
    logic [49:0] prev_bits, cur_bits;
    pattern = 1;
    bus.cell_ready_in = 1'b0;
    @(posedge clk_in); #1;
    start_in = 1'b1;
    @(posedge clk_in); #1;
    start_in = 1'b0;
    idx = 0; done_cnt = 0; post = 0; stop = 1'b0; stalled = 1'b0; prev_bits = '0;
    for (int k = 0; k < N + 15000 && !stop; k++) begin
      start_in = (k == 100) ? 1'b1 : 1'b0;
      if (k == 100) begin
        checks++;
        if (busy_out !== 1'b1) begin
          errors++;
          $display("FAIL scan_busy got busy=%b want 1", busy_out);
        end
      end
      bus.cell_ready_in = (idx < 1500) ? ($urandom_range(0, 99) < 30) : 1'b1;
      cur_bits = {bus.cell_x_out, bus.cell_y_out, bus.cell_rho_out, bus.cell_ux_out, bus.cell_uy_out};
      if (stalled) begin
        checks++;
        if (bus.cell_valid_out !== 1'b1 || cur_bits !== prev_bits) begin
          errors++;
          $display("FAIL stall_hold idx=%0d got valid=%b data=%h want 1 %h", idx, bus.cell_valid_out,
                   cur_bits, prev_bits);
        end
      end
      if (done_out === 1'b1) done_cnt++;
      if (bus.cell_valid_out === 1'b1 && bus.cell_ready_in === 1'b1) begin
        ax = int'(bus.cell_x_out); ay = int'(bus.cell_y_out); arho = int'(bus.cell_rho_out);
        aux = int'($signed(bus.cell_ux_out)); auy = int'($signed(bus.cell_uy_out));
        if (idx == N - 2) begin
          start_in = 1'b1;
          checks++;
          if (busy_out !== 1'b1) begin
            errors++;
            $display("FAIL drain_busy got busy=%b want 1", busy_out);
          end
        end
        if (idx == 0 || idx == 1) begin
          checks++;
          if ((idx == 0 && (auy != 765 || aux != 0 || arho != 765)) ||
              (idx == 1 && (aux != -765 || auy != 0 || arho != 765))) begin
            errors++;
            $display("FAIL signed_extreme idx=%0d got rho=%0d ux=%0d uy=%0d", idx, arho, aux, auy);
          end
        end
        exp_cell(idx, ex, ey, erho, eux, euy);
        checks++;
        if (ax != ex || ay != ey || arho != erho || aux != eux || auy != euy) begin
          errors++;
          $display("FAIL bp_cell idx=%0d got x=%0d y=%0d rho=%0d ux=%0d uy=%0d want %0d %0d %0d %0d %0d",
                   idx, ax, ay, arho, aux, auy, ex, ey, erho, eux, euy);
        end
        idx++;
      end
      stalled = (bus.cell_valid_out === 1'b1) && (bus.cell_ready_in === 1'b0);
      prev_bits = cur_bits;
      if (done_cnt > 0) begin
        post++;
        if (post > 5) stop = 1'b1;
      end
      @(posedge clk_in); #1;
    end
    start_in = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (done_out === 1'b1) done_cnt++;
      @(posedge clk_in); #1;
    end
    checks++;
    if (idx != N) begin
      errors++;
      $display("FAIL bp_count got %0d cells want %0d", idx, N);
    end
    checks++;
    if (done_cnt != 1) begin
      errors++;
      $display("FAIL bp_done_count got %0d want 1", done_cnt);
    end
    checks++;
    if (busy_out !== 1'b0 || bus.cell_valid_out !== 1'b0 || bus.addr_out !== '0) begin
      errors++;
      $display("FAIL start_ignored got busy=%b valid=%b addr=%0d want 0 0 0", busy_out,
               bus.cell_valid_out, bus.addr_out);
    end
  endtask

  initial begin
    rst_in = 1'b0;
    start_in = 1'b0;
    bus.cell_ready_in = 1'b0;
    test_reset();
    test_uniform();
    test_backpressure();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog got simulation still running want finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
